// File: rtl/bias_add_12.sv
// Layer-12 bias add: per frame loads KERN biases, then adds/shifts/saturates/ReLUs each accumulator word.
// One cycle from accumulator pop to output write eligibility; a full output FIFO holds the result and blocks pops.
module bias_add_12 #(
  parameter int KERN        = 16,
  parameter int NUM_PIX     = 64,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int SHIFT       = 8,
  parameter int RELU        = 1
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [COEFF_WIDTH-1:0] bias_V_dout,
  input  logic                   bias_V_empty_n,
  output logic                   bias_V_read,
  input  logic [ACC_WIDTH-1:0]   acc_V_dout,
  input  logic                   acc_V_empty_n,
  output logic                   acc_V_read,
  output logic [DATA_WIDTH-1:0]  output_V_din,
  input  logic                   output_V_full_n,
  output logic                   output_V_write,
  output logic                   frame_done
);

  localparam int KW = (KERN > 1) ? $clog2(KERN) : 1;
  localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KERN - 1);
  localparam logic [PW-1:0] P_LAST = PW'(NUM_PIX - 1);

  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH + 1 - DATA_WIDTH){1'b0}}, 1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [KW-1:0]                 bias_cnt;
  logic [KW-1:0]                 ch;
  logic [PW-1:0]                 pix;
  logic                          valid;
  logic [DATA_WIDTH-1:0]         dout;
  logic signed [COEFF_WIDTH-1:0] bias_reg [KERN];

  logic bias_pop;
  logic acc_pop;
  logic wr;
  logic last_bias;
  logic last_word;

  // The sum is one bit wider than the accumulator so the add can never wrap.
  function automatic logic [DATA_WIDTH-1:0] bias_fn(
    input logic signed [ACC_WIDTH-1:0]   a,
    input logic signed [COEFF_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH:0] s;
    logic signed [ACC_WIDTH:0] t;
    logic [DATA_WIDTH-1:0]     r;
    s = {a[ACC_WIDTH-1], a} + {{(ACC_WIDTH + 1 - COEFF_WIDTH){b[COEFF_WIDTH-1]}}, b};
    t = s >>> SHIFT;
    if (RELU != 0 && t[ACC_WIDTH]) begin
      r = '0;
    end else if (t > SAT_MAX) begin
      r = SAT_MAX[DATA_WIDTH-1:0];
    end else if (t < SAT_MIN) begin
      r = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      r = t[DATA_WIDTH-1:0];
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    bias_pop  = 1'b0;
    acc_pop   = 1'b0;
    wr        = valid && output_V_full_n && !ap_rst;
    last_bias = (bias_cnt == K_LAST);
    last_word = (ch == K_LAST) && (pix == P_LAST);
    case (state)
      LOAD: begin
        bias_pop = bias_V_empty_n && !ap_rst;
        if (bias_pop && last_bias) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        acc_pop = acc_V_empty_n && (!valid || output_V_full_n) && !ap_rst;
        if (acc_pop && last_word) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (wr) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      bias_cnt <= '0;
      ch       <= '0;
      pix      <= '0;
      valid    <= 1'b0;
      dout     <= '0;
    end else begin
      if (bias_pop) begin
        if (last_bias) begin
          bias_cnt <= '0;
          ch       <= '0;
          pix      <= '0;
        end else begin
          bias_cnt <= bias_cnt + 1'b1;
        end
      end
      // A pop refills the register in the same cycle it is drained, so valid stays set.
      if (acc_pop) begin
        dout  <= bias_fn(acc_V_dout, bias_reg[ch]);
        valid <= 1'b1;
        if (ch == K_LAST) begin
          ch  <= '0;
          pix <= (pix == P_LAST) ? '0 : pix + 1'b1;
        end else begin
          ch <= ch + 1'b1;
        end
      end else if (wr) begin
        valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (bias_pop) begin
      bias_reg[bias_cnt] <= bias_V_dout;
    end
  end

  assign bias_V_read    = bias_pop;
  assign acc_V_read     = acc_pop;
  assign output_V_write = wr;
  assign output_V_din   = dout;
  assign frame_done     = (state == DRAIN) && wr;

endmodule

// File: tb/tb_bias_add_12.sv
// Randomised bench for bias_add_12: FIFO-model stimulus, arithmetic reference model, RELU=1 and RELU=0 twins.
module tb_bias_add_12;

  localparam int K  = 4;
  localparam int NP = 2;
  localparam int FW = K * NP;
  localparam int CW = 16;
  localparam int AW = 32;
  localparam int DW = 16;
  localparam int SH = 8;
  localparam int BASIC_EXP [4]    = '{1, 0, 0, 2};
  localparam int BASIC_EXP_NR [4] = '{1, -1, 0, 2};

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic [CW-1:0] bias_V_dout;
  logic          bias_V_empty_n;
  logic [AW-1:0] acc_V_dout;
  logic          acc_V_empty_n;
  logic          output_V_full_n;
  logic          bias_V_read, acc_V_read, output_V_write, frame_done;
  logic [DW-1:0] output_V_din;
  logic          bias_V_read_nr, acc_V_read_nr, output_V_write_nr, frame_done_nr;
  logic [DW-1:0] output_V_din_nr;

  always #5 ap_clk = ~ap_clk;

  bias_add_12 #(.KERN(K), .NUM_PIX(NP), .COEFF_WIDTH(CW), .ACC_WIDTH(AW),
                .DATA_WIDTH(DW), .SHIFT(SH), .RELU(1)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read),
    .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(acc_V_read),
    .output_V_din(output_V_din), .output_V_full_n(output_V_full_n),
    .output_V_write(output_V_write), .frame_done(frame_done));

  bias_add_12 #(.KERN(K), .NUM_PIX(NP), .COEFF_WIDTH(CW), .ACC_WIDTH(AW),
                .DATA_WIDTH(DW), .SHIFT(SH), .RELU(0)) dut_nr (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .bias_V_dout(bias_V_dout), .bias_V_empty_n(bias_V_empty_n), .bias_V_read(bias_V_read_nr),
    .acc_V_dout(acc_V_dout), .acc_V_empty_n(acc_V_empty_n), .acc_V_read(acc_V_read_nr),
    .output_V_din(output_V_din_nr), .output_V_full_n(output_V_full_n),
    .output_V_write(output_V_write_nr), .frame_done(frame_done_nr));

  int n_pass   = 0;
  int n_checks = 0;

  logic signed [CW-1:0] bias_q [$];
  logic signed [AW-1:0] acc_q [$];
  int exp_q [$];
  int exp_nr_q [$];
  int got_q [$];
  int got_nr_q [$];
  bit got_fd [$];
  int wr_cyc [$];

  logic signed [CW-1:0] fb [K];
  logic signed [AW-1:0] fa [FW];

  int p_bias = 100;
  int p_acc  = 100;
  int full_mode = 0;
  bit tog = 1'b1;
  int loaded = 0;
  int pops = 0;
  int writes = 0;
  int wr_in_frame = 0;
  int cyc = 0;
  bit last_ar = 1'b0;
  bit prev_hold = 1'b0;
  logic [DW-1:0] prev_od = '0;
  int v_acc_load, v_bias_run, v_unstable, v_fd, v_twin;

  // Reference: sum, floor-divide by 2^SH, clamp to the output range, then optional ReLU.
  function automatic int ref_f(input longint a, input longint b, input bit relu);
    longint s, r, t, sc, hi, lo;
    sc = longint'(1) << SH;
    s  = a + b;
    r  = s % sc;
    if (r < 0) r = r + sc;
    t  = (s - r) / sc;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    if (t > hi) t = hi;
    if (t < lo) t = lo;
    if (relu && t < 0) t = 0;
    return int'(t);
  endfunction

  task automatic clear_sb();
    exp_q.delete(); exp_nr_q.delete(); got_q.delete(); got_nr_q.delete();
    got_fd.delete(); wr_cyc.delete();
    v_acc_load = 0; v_bias_run = 0; v_unstable = 0; v_fd = 0; v_twin = 0;
    pops = 0; writes = 0; wr_in_frame = 0; loaded = 0; prev_hold = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < K; i++) fb[i] = CW'($urandom);
    for (int i = 0; i < FW; i++) begin
      case ($urandom_range(3))
        0: fa[i] = AW'(int'($urandom_range(2097152)) - 1048576);
        1: fa[i] = AW'($urandom);
        2: fa[i] = ($urandom_range(1) == 1) ? 32'h7FFF_FFFF : 32'h8000_0000;
        default: fa[i] = AW'(int'($urandom_range(1024)) - 512);
      endcase
    end
  endtask

  task automatic push_frame(input int nb);
    for (int i = 0; i < nb; i++) bias_q.push_back(fb[i]);
    for (int i = 0; i < FW; i++) begin
      acc_q.push_back(fa[i]);
      exp_q.push_back(ref_f(longint'(fa[i]), longint'(fb[i % K]), 1'b1));
      exp_nr_q.push_back(ref_f(longint'(fa[i]), longint'(fb[i % K]), 1'b0));
    end
  endtask

  task automatic cycle();
    bit br, ar, ow;
    @(negedge ap_clk);
    bias_V_empty_n = 1'b0;
    bias_V_dout    = '0;
    if (bias_q.size() > 0) begin
      bias_V_dout    = bias_q[0];
      bias_V_empty_n = int'($urandom_range(99)) < p_bias;
    end
    acc_V_empty_n = 1'b0;
    acc_V_dout    = '0;
    if (acc_q.size() > 0) begin
      acc_V_dout    = acc_q[0];
      acc_V_empty_n = int'($urandom_range(99)) < p_acc;
    end
    case (full_mode)
      0: output_V_full_n = 1'b1;
      1: begin output_V_full_n = tog; tog = !tog; end
      default: output_V_full_n = ($urandom_range(1) == 1);
    endcase
    #1;
    br = bias_V_read; ar = acc_V_read; ow = output_V_write; last_ar = ar;
    if (prev_hold && output_V_din !== prev_od) v_unstable++;
    prev_hold = (pops > writes) && !output_V_full_n;
    prev_od   = output_V_din;
    if (ar && loaded < K) v_acc_load++;
    if (br && loaded == K) v_bias_run++;
    if (frame_done && !ow) v_fd++;
    if ({bias_V_read, acc_V_read, output_V_write, frame_done} !==
        {bias_V_read_nr, acc_V_read_nr, output_V_write_nr, frame_done_nr}) v_twin++;
    if (ow) begin
      got_q.push_back(int'($signed(output_V_din)));
      got_nr_q.push_back(int'($signed(output_V_din_nr)));
      got_fd.push_back(frame_done);
      wr_cyc.push_back(cyc);
    end
    @(posedge ap_clk);
    cyc++;
    if (br) begin void'(bias_q.pop_front()); loaded++; end
    if (ar) begin void'(acc_q.pop_front()); pops++; end
    if (ow) begin
      writes++;
      wr_in_frame++;
      if (wr_in_frame == FW) begin wr_in_frame = 0; loaded = 0; end
    end
  endtask

  task automatic run_out(input int budget);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin cycle(); n++; end
    for (int i = 0; i < 3; i++) cycle();
  endtask

  task automatic test_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1; bias_V_empty_n = 1'b1; acc_V_empty_n = 1'b1; output_V_full_n = 1'b1;
    bias_V_dout = 16'h1234; acc_V_dout = 32'h0001_0000;
    #1;
    n_checks++; if (bias_V_read !== 1'b0) $display("FAIL reset_bias_read: got %b, required 0", bias_V_read); else n_pass++;
    n_checks++; if (acc_V_read !== 1'b0) $display("FAIL reset_acc_read: got %b, required 0", acc_V_read); else n_pass++;
    n_checks++; if (output_V_write !== 1'b0) $display("FAIL reset_write: got %b, required 0", output_V_write); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b, required 0", frame_done); else n_pass++;
    n_checks++; if (output_V_din !== '0) $display("FAIL reset_din: got %h, required 0", output_V_din); else n_pass++;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0; bias_V_empty_n = 1'b0; acc_V_empty_n = 1'b0;
    clear_sb();
  endtask

  task automatic test_basic();
    clear_sb(); p_bias = 100; p_acc = 100; full_mode = 0;
    fb[0] = 256; fb[1] = -256; fb[2] = 0; fb[3] = 512;
    for (int i = 0; i < FW; i++) fa[i] = '0;
    push_frame(K);
    run_out(200);
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL basic_count: got %0d words, required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== BASIC_EXP[i] || got_nr_q[i] !== BASIC_EXP_NR[i])
        $display("FAIL basic_word%0d: got %0d/%0d, required %0d/%0d", i, got_q[i], got_nr_q[i], BASIC_EXP[i], BASIC_EXP_NR[i]);
      else n_pass++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_nr_q[i] !== exp_nr_q[i] || got_fd[i] !== (i % FW == FW - 1))
        $display("FAIL basic_model%0d: got %0d/%0d fd=%0b, required %0d/%0d fd=%0b", i, got_q[i], got_nr_q[i], got_fd[i], exp_q[i], exp_nr_q[i], i % FW == FW - 1);
      else n_pass++;
    end
    n_checks++; if (v_acc_load + v_bias_run + v_unstable + v_fd + v_twin != 0) $display("FAIL basic_protocol: got %0d/%0d/%0d/%0d/%0d violations, required 0", v_acc_load, v_bias_run, v_unstable, v_fd, v_twin); else n_pass++;
  endtask

  task automatic test_saturation();
    clear_sb(); p_bias = 100; p_acc = 100; full_mode = 0;
    fb[0] = 1000; fb[1] = 0; fb[2] = -32768; fb[3] = 32767;
    fa[0] = 32'h7FFF_FFFF; fa[1] = 32'h8000_0000; fa[2] = 32'h8000_0000; fa[3] = 32'h7FFF_FFFF;
    fa[4] = -1000; fa[5] = -1; fa[6] = 32'h00FF_FFFF; fa[7] = -8388608;
    push_frame(K);
    run_out(200);
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL sat_count: got %0d words, required %0d", got_q.size(), exp_q.size()); else n_pass++;
    if (got_q.size() >= 2) begin
      n_checks++; if (got_q[0] !== 32767) $display("FAIL sat_high: got %0d, required 32767", got_q[0]); else n_pass++;
      n_checks++; if (got_nr_q[1] !== -32768) $display("FAIL sat_low_norelu: got %0d, required -32768", got_nr_q[1]); else n_pass++;
      n_checks++; if (got_q[1] !== 0) $display("FAIL sat_low_relu: got %0d, required 0", got_q[1]); else n_pass++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_nr_q[i] !== exp_nr_q[i] || got_fd[i] !== (i % FW == FW - 1))
        $display("FAIL sat_model%0d: got %0d/%0d fd=%0b, required %0d/%0d", i, got_q[i], got_nr_q[i], got_fd[i], exp_q[i], exp_nr_q[i]);
      else n_pass++;
    end
    n_checks++; if (v_acc_load + v_bias_run + v_unstable + v_fd + v_twin != 0) $display("FAIL sat_protocol: got %0d/%0d/%0d/%0d/%0d violations, required 0", v_acc_load, v_bias_run, v_unstable, v_fd, v_twin); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clear_sb(); p_bias = 100; p_acc = 100; full_mode = 0;
    for (int f = 0; f < 2; f++) begin fill_random(); push_frame(K); end
    run_out(400);
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d words, required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int f = 0; f < 2; f++) begin
      n_checks++;
      if (f * FW + FW - 1 >= wr_cyc.size())
        $display("FAIL b2b_span%0d: got %0d writes, required %0d", f, wr_cyc.size(), (f + 1) * FW);
      else if (wr_cyc[f * FW + FW - 1] - wr_cyc[f * FW] != FW - 1)
        $display("FAIL b2b_span%0d: got %0d cycles, required %0d", f, wr_cyc[f * FW + FW - 1] - wr_cyc[f * FW], FW - 1);
      else n_pass++;
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_nr_q[i] !== exp_nr_q[i] || got_fd[i] !== (i % FW == FW - 1))
        $display("FAIL b2b_model%0d: got %0d/%0d fd=%0b, required %0d/%0d", i, got_q[i], got_nr_q[i], got_fd[i], exp_q[i], exp_nr_q[i]);
      else n_pass++;
    end
    n_checks++; if (v_acc_load + v_bias_run + v_unstable + v_fd + v_twin != 0) $display("FAIL b2b_protocol: got %0d/%0d/%0d/%0d/%0d violations, required 0", v_acc_load, v_bias_run, v_unstable, v_fd, v_twin); else n_pass++;
  endtask

  task automatic test_throttle(input int mode, input int pin);
    clear_sb(); p_bias = pin; p_acc = pin; full_mode = mode;
    for (int f = 0; f < 2; f++) begin fill_random(); push_frame(K); end
    run_out(2000);
    full_mode = 0;
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL throttle%0d_count: got %0d words, required %0d", mode, got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_nr_q[i] !== exp_nr_q[i] || got_fd[i] !== (i % FW == FW - 1))
        $display("FAIL throttle%0d_model%0d: got %0d/%0d fd=%0b, required %0d/%0d", mode, i, got_q[i], got_nr_q[i], got_fd[i], exp_q[i], exp_nr_q[i]);
      else n_pass++;
    end
    n_checks++; if (v_acc_load + v_bias_run + v_unstable + v_fd + v_twin != 0) $display("FAIL throttle%0d_protocol: got %0d/%0d/%0d/%0d/%0d violations, required 0", mode, v_acc_load, v_bias_run, v_unstable, v_fd, v_twin); else n_pass++;
    p_bias = 100; p_acc = 100;
  endtask

  task automatic test_bias_stall();
    clear_sb(); p_bias = 100; p_acc = 100; full_mode = 0;
    fill_random();
    push_frame(2);
    for (int i = 0; i < 4; i++) cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++; if (last_ar !== 1'b0) $display("FAIL stall_acc_read%0d: got %b, required 0", i, last_ar); else n_pass++;
    end
    for (int i = 2; i < K; i++) bias_q.push_back(fb[i]);
    run_out(200);
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL stall_count: got %0d words, required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_nr_q[i] !== exp_nr_q[i] || got_fd[i] !== (i % FW == FW - 1))
        $display("FAIL stall_model%0d: got %0d/%0d fd=%0b, required %0d/%0d", i, got_q[i], got_nr_q[i], got_fd[i], exp_q[i], exp_nr_q[i]);
      else n_pass++;
    end
    n_checks++; if (v_acc_load + v_bias_run + v_unstable + v_fd + v_twin != 0) $display("FAIL stall_protocol: got %0d/%0d/%0d/%0d/%0d violations, required 0", v_acc_load, v_bias_run, v_unstable, v_fd, v_twin); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_sb(); p_bias = 100; p_acc = 100; full_mode = 0;
    fill_random(); push_frame(K);
    while (pops < K + 2 && n < 200) begin cycle(); n++; end
    n_checks++; if (pops !== K + 2) $display("FAIL rstmid_reach: got %0d pops, required %0d", pops, K + 2); else n_pass++;
    @(negedge ap_clk);
    ap_rst = 1'b1; bias_V_empty_n = 1'b1; acc_V_empty_n = 1'b1; output_V_full_n = 1'b1;
    #1;
    n_checks++; if (output_V_write !== 1'b0) $display("FAIL rstmid_write: got %b, required 0", output_V_write); else n_pass++;
    n_checks++; if (acc_V_read !== 1'b0 || bias_V_read !== 1'b0) $display("FAIL rstmid_reads: got %b%b, required 00", acc_V_read, bias_V_read); else n_pass++;
    n_checks++; if (output_V_din !== '0) $display("FAIL rstmid_din: got %h, required 0", output_V_din); else n_pass++;
    @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b0; bias_V_empty_n = 1'b0; acc_V_empty_n = 1'b0;
    bias_q.delete(); acc_q.delete(); clear_sb();
    fill_random(); push_frame(K);
    run_out(200);
    n_checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rstmid_count: got %0d words, required %0d", got_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i] || got_nr_q[i] !== exp_nr_q[i] || got_fd[i] !== (i % FW == FW - 1))
        $display("FAIL rstmid_model%0d: got %0d/%0d fd=%0b, required %0d/%0d", i, got_q[i], got_nr_q[i], got_fd[i], exp_q[i], exp_nr_q[i]);
      else n_pass++;
    end
    n_checks++; if (v_acc_load + v_bias_run + v_unstable + v_fd + v_twin != 0) $display("FAIL rstmid_protocol: got %0d/%0d/%0d/%0d/%0d violations, required 0", v_acc_load, v_bias_run, v_unstable, v_fd, v_twin); else n_pass++;
  endtask

  initial begin
    ap_rst = 1'b1;
    bias_V_dout = '0; bias_V_empty_n = 1'b0;
    acc_V_dout = '0; acc_V_empty_n = 1'b0;
    output_V_full_n = 1'b1;
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_throttle(1, 100);
    test_throttle(2, 60);
    test_bias_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
